// File: rtl/frame_reader.sv
// frame_reader: streams a SRC_W x SRC_H frame from a synchronous-read buffer, upscaled by SCALE on both axes.
// Latency: first m_valid 2 cycles after start is sampled; 1 pixel/cycle while m_ready is high.
// Backpressure: 2-entry output FIFO; a read issues only if FIFO + in-flight stays below 2, so addr holds when stalled.
// Option: define FRAME_READER_FREERUN_EN to stream frames back to back (no DRAIN/IDLE, done never pulses).
module frame_reader #(
  parameter int SRC_W      = 320,
  parameter int SRC_H      = 240,
  parameter int SCALE      = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  busy,
  output logic                  done
);

  localparam int OUT_W = SRC_W * SCALE;
  localparam int OUT_H = SRC_H * SCALE;
  localparam int XW    = $clog2(OUT_W + 1);
  localparam int YW    = $clog2(OUT_H + 1);
  localparam int SW    = $clog2(SCALE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SRC_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr, r_row_base;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [SW-1:0]         r_sx, r_sy;
  logic                  r_inflight, r_inf_sof, r_inf_eol;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH+1:0] r_q0, r_q1;
  logic                  r_done;
  logic                  w_pop, w_issue, w_fin, w_last_pix;
  logic [2:0]            w_level;
  logic [DATA_WIDTH+1:0] w_in;

  // FIFO entry = {pixel, sof, eol}; the flags travel with the read they were issued for
  assign w_in       = {data, r_inf_sof, r_inf_eol};
  assign w_pop      = (r_cnt != 2'd0) && m_ready;
  // occupancy after this cycle, counting the read landing now and the beat leaving now
  assign w_level    = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);

  assign addr    = r_addr;
  assign m_valid = (r_cnt != 2'd0);
  assign m_data  = r_q0[DATA_WIDTH+1:2];
  assign m_sof   = r_q0[1];
  assign m_eol   = r_q0[0];
  assign done    = r_done;

  // State register and done pulse (done follows the final acceptance by one cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_fin;
    end
  end

  // Next state, read-issue decision and busy
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_fin        = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        w_issue = (w_level < 3'd2);
        if (w_issue && w_last_pix) begin
`ifdef FRAME_READER_FREERUN_EN
          w_next_state = S_RUN;
`else
          w_next_state = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        // no reads left to issue: the only remaining beat is the last of the frame
        if (w_pop && (r_cnt == 2'd1) && !r_inflight) begin
          w_next_state = S_IDLE;
          w_fin        = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Raster counters and address generation; row base steps by SRC_W every SCALE lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_row_base <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_inflight <= 1'b0;
      r_inf_sof  <= 1'b0;
      r_inf_eol  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_sof <= (r_x == '0) && (r_y == '0);
        r_inf_eol <= (r_x == X_LAST);
        if (r_x == X_LAST) begin
          r_x  <= '0;
          r_sx <= '0;
          if (r_y == Y_LAST) begin
            r_y        <= '0;
            r_sy       <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
          end else begin
            r_y <= r_y + YW'(1);
            if (r_sy == S_LAST) begin
              r_sy       <= '0;
              r_row_base <= r_row_base + ROW_STEP;
              r_addr     <= r_row_base + ROW_STEP;
            end else begin
              r_sy   <= r_sy + SW'(1);
              r_addr <= r_row_base;
            end
          end
        end else begin
          r_x <= r_x + XW'(1);
          if (r_sx == S_LAST) begin
            r_sx   <= '0;
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end else begin
            r_sx <= r_sx + SW'(1);
          end
        end
      end
    end
  end

  // Two-entry output FIFO; head entry drives the output port directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= w_in;
          else               r_q1 <= w_in;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= w_in;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= w_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
